// File: rtl/lx32_mem_pkg.sv
// Shared types and helpers for the data-memory controller.
//   mem_size_t   : access size encoding on mem_size[1:0] (2'b11 is illegal)
//   dmem_state_t : controller FSM states
//   be_for       : byte enables for a store of a given size at a byte offset
//   size_ok      : legality/alignment check for a request
//   lane_wdata   : replicate store data across the lanes it may land in
package lx32_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    DONE   = 2'b11
  } dmem_state_t;

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: be_for = 4'b0001 << offset;
      SZ_HALF: be_for = 4'b0011 << offset;
      default: be_for = 4'hF;
    endcase
  endfunction

  function automatic logic size_ok(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: size_ok = 1'b1;
      SZ_HALF: size_ok = ~offset[0];
      SZ_WORD: size_ok = (offset == 2'b00);
      default: size_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: lane_wdata = {4{d[7:0]}};
      SZ_HALF: lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select and extension (combinational).
//   rdata_i  : raw 32-bit bus read data
//   offset_i : byte offset of the access (addr[1:0])
//   size_i   : [1:0] access size, [2] unsigned load
//   data_o   : selected byte/half/word, sign- or zero-extended
module dmem_load_align
  import lx32_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[{offset_i, 3'b000} +: 8];
    half_c = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i[1:0])
      SZ_BYTE: data_o = size_i[2] ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: data_o = size_i[2] ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the lsu and a req/gnt/rvalid data bus.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   mem_addr/mem_wdata  : byte address and LSB-justified store data from lsu
//   mem_we/mem_re       : store / load request (store wins if both set)
//   mem_size            : [1:0] size, [2] unsigned load
//   stall               : core hold while an access is outstanding
//   load_data/load_valid: extended load result and its completion pulse
//   misalign            : pulse for a rejected (illegal/misaligned) request
//   bus_err             : pulse for a timeout abort
//   bus_req..bus_be     : bus request channel
//   bus_gnt/bus_rvalid/bus_rdata : bus response channel
module dmem_ctrl
  import lx32_mem_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_we,
  input  logic             mem_re,
  input  logic [2:0]       mem_size,
  output logic             stall,
  output logic [WIDTH-1:0] load_data,
  output logic             load_valid,
  output logic             misalign,
  output logic             bus_err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [3:0]       bus_be,
  input  logic             bus_gnt,
  input  logic             bus_rvalid,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [2:0]       size_q, size_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic             mis_q, mis_d;

  logic             req_valid_c;
  logic             aligned_c;
  logic             tmo_c;
  logic [WIDTH-1:0] align_data_c;

  assign req_valid_c = mem_we | mem_re;
  assign aligned_c   = size_ok(mem_size[1:0], mem_addr[1:0]);
  // Abort on the last allowed cycle; TIMEOUT of 0 never aborts.
  assign tmo_c       = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  dmem_load_align u_load_align (
    .rdata_i  (bus_rdata),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .data_o   (align_data_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ld_d    = ld_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (req_valid_c) begin
          if (aligned_c) begin
            state_d = REQ;
            cnt_d   = '0;
            addr_d  = mem_addr;
            we_d    = mem_we;
            size_d  = mem_size;
            be_d    = mem_we ? be_for(mem_size[1:0], mem_addr[1:0]) : 4'hF;
            wdata_d = mem_we ? lane_wdata(mem_size[1:0], mem_wdata) : '0;
          end else begin
            // Skip the check during the pulse cycle so a held request pulses every other cycle.
            mis_d = ~mis_q;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_gnt) begin
          if (we_q) begin
            state_d = DONE;
          end else if (bus_rvalid) begin
            state_d = DONE;
            ld_d    = align_data_c;
          end else begin
            state_d = WAIT_R;
          end
        end else if (tmo_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          state_d = DONE;
          ld_d    = align_data_c;
        end else if (tmo_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; stall is gated by rst so it drops the moment reset asserts.
  always_comb begin
    stall      = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_be     = '0;
    load_valid = 1'b0;
    bus_err    = 1'b0;
    load_data  = ld_q;
    misalign   = mis_q;
    case (state_q)
      IDLE: begin
        stall = ~rst & req_valid_c & aligned_c;
      end
      REQ: begin
        stall     = ~rst;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[WIDTH-1:2], 2'b00};
        bus_wdata = wdata_q;
        bus_be    = be_q;
      end
      WAIT_R: begin
        stall = ~rst;
      end
      DONE: begin
        load_valid = ~we_q & ~err_q;
        bus_err    = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [2:0]  mem_size;
  logic        stall, load_valid, misalign, bus_err;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_ld = 32'h0;

  dmem_ctrl #(.WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_size(mem_size),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: expected load value from the extraction rules
  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] raw, v;
    raw = rd >> (8 * off);
    case (size[1:0])
      2'd0: begin v = raw & 32'hFF;   if (!size[2] && v[7])  v = v + 32'hFFFFFF00; end
      2'd1: begin v = raw & 32'hFFFF; if (!size[2] && v[15]) v = v + 32'hFFFF0000; end
      default: v = raw;
    endcase
    return v;
  endfunction

  // One access; g = REQ cycle carrying gnt (0 = never), r = rvalid delay after gnt.
  task automatic run_txn(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] size,
                         input int g, input int r, input logic [31:0] rd);
    logic        store, mis, err;
    logic [1:0]  off;
    int          sz, nb, done, req_end;
    logic [3:0]  be_exp;
    logic [31:0] wd_exp, mask;
    store = we;
    off   = addr[1:0];
    sz    = int'(size[1:0]);
    mis   = (sz == 3) || (sz == 1 && off[0]) || (sz == 2 && off != 2'd0);
    nb    = (sz < 3) ? (1 << sz) : 4;
    be_exp = store ? 4'(((1 << nb) - 1) << off) : 4'hF;
    mask   = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    wd_exp = (sz == 0) ? (wd & mask) * 32'h0101_0101 :
             (sz == 1) ? (wd & mask) * 32'h0001_0001 : wd;

    @(posedge clk); #1;
    mem_we = we; mem_re = re; mem_addr = addr; mem_wdata = wd; mem_size = size;
    bus_gnt = 1'b0; bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", stall, !mis);
    chk("idle_req", bus_req, 1'b0);

    if (mis) begin
      @(posedge clk); #1;
      mem_we = 1'b0; mem_re = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);
      chk("mis_pulse", misalign, 1'b1);
      chk("mis_stall", stall, 1'b0);
      chk("mis_req", bus_req, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_end", misalign, 1'b0);
      return;
    end

    if (store) begin
      err  = !(g >= 1 && g <= int'(T));
      done = err ? int'(T) + 1 : g + 1;
    end else begin
      err  = !(g >= 1 && g <= int'(T) && g + r <= int'(T));
      done = err ? int'(T) + 1 : g + r + 1;
    end
    req_end = (g >= 1 && g < done) ? g : done - 1;
    if (!store && !err) exp_ld = ref_load(size, off, rd);

    for (int k = 1; k <= done; k++) begin
      @(posedge clk); #1;
      bus_gnt   = (k == g);
      bus_rdata = $urandom;
      if (store) bus_rvalid = 1'($urandom_range(0, 1));
      else       bus_rvalid = (g != 0) && (k == g + r);
      if (!store && bus_rvalid) bus_rdata = rd;
      if (k == done) begin
        mem_we = 1'b0; mem_re = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      end
      @(negedge clk);
      if (k < done) begin
        chk("busy_stall", stall, 1'b1);
        chk("busy_req", bus_req, k <= req_end);
        if (k <= req_end) begin
          chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
          chk("bus_be", bus_be, be_exp);
          chk("bus_we", bus_we, store);
          if (store) chk("bus_wdata", bus_wdata, wd_exp);
        end
      end else begin
        chk("done_stall", stall, 1'b0);
        chk("done_req", bus_req, 1'b0);
        chk("load_valid", load_valid, !store && !err);
        chk("bus_err", bus_err, err);
        chk("load_data", load_data, exp_ld);
      end
    end
    // Back in IDLE; a late rvalid must not disturb anything.
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = $urandom;
    @(negedge clk);
    chk("post_valid", load_valid, 1'b0);
    chk("post_err", bus_err, 1'b0);
    chk("post_data", load_data, exp_ld);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0; mem_size = 3'b010;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_lvalid", load_valid, 1'b0);
    chk("rst_mis", misalign, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases
    run_txn(1, 0, 32'h10, 32'hDEADBEEF, 3'b010, 2, 0, 0);
    run_txn(1, 0, 32'h13, 32'h000000AB, 3'b000, 1, 0, 0);
    run_txn(0, 1, 32'h21, 32'h0, 3'b000, 1, 1, 32'h0000_8000);
    chk("sbyte_val", exp_ld, 32'hFFFF_FF80);
    run_txn(0, 1, 32'h21, 32'h0, 3'b100, 1, 1, 32'h0000_8000);
    chk("ubyte_val", load_data, 32'h0000_0080);
    run_txn(0, 1, 32'h22, 32'h0, 3'b001, 1, 0, 32'h1234_5678);
    chk("half_val", load_data, 32'h0000_1234);
    run_txn(1, 0, 32'h06, 32'h1, 3'b001, 1, 0, 0);
    run_txn(0, 1, 32'h06, 32'h0, 3'b010, 1, 0, 0);
    run_txn(0, 1, 32'h00, 32'h0, 3'b011, 1, 0, 0);
    run_txn(1, 1, 32'h32, 32'h0000_BEEF, 3'b001, 3, 0, 32'h5555_5555);
    run_txn(1, 0, 32'h40, 32'h0, 3'b010, 0, 0, 0);
    run_txn(0, 1, 32'h44, 32'h0, 3'b010, 2, 20, 32'hCAFE_F00D);
    run_txn(0, 1, 32'h48, 32'h0, 3'b010, 4, 12, 32'hCAFE_F00D);

    // Held misaligned request pulses every other cycle
    @(posedge clk); #1;
    mem_re = 1'b1; mem_addr = 32'h3; mem_size = 3'b010;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_hold", misalign, (k % 2) == 1);
      chk("mis_hold_req", bus_req, 1'b0);
    end
    @(posedge clk); #1;
    mem_re = 1'b0;
    @(posedge clk); #1;

    // Reset while waiting for read data
    mem_re = 1'b1; mem_addr = 32'h50; mem_size = 3'b010;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("wr_stall", stall, 1'b1);
    chk("wr_req", bus_req, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", stall, 1'b0);
    chk("arst_req", bus_req, 1'b0);
    chk("arst_ldata", load_data, 32'h0);
    exp_ld = 32'h0;
    mem_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      logic        we, re;
      logic [2:0]  sz;
      int          g, r;
      we = 1'($urandom_range(0, 1));
      re = we ? 1'($urandom_range(0, 1)) : 1'b1;
      sz = 3'($urandom_range(0, 7));
      g  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      r  = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(0, 4));
      run_txn(we, re, $urandom, $urandom, sz, g, r, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
